cr_kme_fifo_param: RTL and testbench

Parametrised first-word-fall-through FIFO for the KME datapath. It generalises the fixed 128-bit, 2-slot KME buffer to configurable width, depth and stall slack, and adds a working stall override, a synchronous flush and slot-count outputs. It sits between KME pipeline stages that use a valid/stall input protocol and a valid/ack output protocol.

---
 rtl/cr_kme_fifo_param.sv | 127 ++++++++++++
 tb/tb_cr_kme_fifo_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cr_kme_fifo_param.sv
// Purpose : parametrised first-word-fall-through FIFO between KME pipeline stages.
// Latency : write visible at head 1 cycle after the accepting edge; reads are zero-bubble.
// Backpr. : fifo_in_stall is advisory (free <= STALL_SLACK); writes into a full FIFO without a read are dropped.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   fifo_in/_valid           write data / write request
//   fifo_in_stall_override   forces fifo_in_stall low
//   fifo_clear               synchronous flush, highest priority
//   fifo_out_ack             consumer pops the head entry
//   fifo_in_stall            upstream should stop writing
//   fifo_out/_valid          head entry (zero when empty) / head valid
//   fifo_used_slots/_free    occupancy and DEPTH - occupancy
//   fifo_overflow/_underflow dropped write / ack while empty
//
// Optional feature: define CR_KME_FIFO_STICKY_ERR_EN to make overflow/underflow
// sticky until rst or fifo_clear; otherwise they are one-cycle registered pulses.

module cr_kme_fifo_param #(
   parameter int WIDTH       = 128,
   parameter int DEPTH       = 4,
   parameter int STALL_SLACK = 0,
   parameter int CW          = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] fifo_in,
   input  logic             fifo_in_valid,
   input  logic             fifo_in_stall_override,
   input  logic             fifo_clear,
   input  logic             fifo_out_ack,
   output logic             fifo_in_stall,
   output logic [WIDTH-1:0] fifo_out,
   output logic             fifo_out_valid,
   output logic [CW-1:0]    fifo_used_slots,
   output logic [CW-1:0]    fifo_free_slots,
   output logic             fifo_overflow,
   output logic             fifo_underflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          ovf_q,    ovf_d;
   logic          udf_q,    udf_d;

   logic full;
   logic ren;
   logic wen;
   logic mem_we;
   logic ovf_evt;
   logic udf_evt;

   always_comb begin
      full    = (count_q == CW'(DEPTH));
      ren     = fifo_out_valid & fifo_out_ack;
      // A full FIFO still accepts a write when the head leaves on the same edge.
      wen     = fifo_in_valid & (~full | ren);
      ovf_evt = fifo_in_valid & full & ~ren & ~fifo_clear;
      udf_evt = fifo_out_ack & ~fifo_out_valid & ~fifo_clear;
      mem_we  = wen & ~fifo_clear;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (fifo_clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wen) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
         end
         if (ren) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(wen) - CW'(ren);
      end

`ifdef CR_KME_FIFO_STICKY_ERR_EN
      ovf_d = fifo_clear ? 1'b0 : (ovf_q | ovf_evt);
      udf_d = fifo_clear ? 1'b0 : (udf_q | udf_evt);
`else
      ovf_d = ovf_evt;
      udf_d = udf_evt;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is deliberately left unreset; the count gates what is visible.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= fifo_in;
      end
   end

   always_comb begin
      fifo_out_valid  = (count_q != '0);
      fifo_out        = fifo_out_valid ? mem_q[rd_ptr_q] : '0;
      fifo_used_slots = count_q;
      fifo_free_slots = CW'(DEPTH) - count_q;
      fifo_in_stall   = (int'(fifo_free_slots) <= STALL_SLACK) & ~fifo_in_stall_override;
      fifo_overflow   = ovf_q;
      fifo_underflow  = udf_q;
   end

endmodule

// File: tb/tb_cr_kme_fifo_param.sv
// Bench for cr_kme_fifo_param: two instances (STALL_SLACK 0 and 1) share stimulus
// and are compared every cycle against a queue-based model, plus literal checks.
// Summary: "test done: total=N bad=M".

module tb_cr_kme_fifo_param;

   localparam int W  = 32;
   localparam int D  = 4;
   localparam int CW = $clog2(D + 1);
`ifdef CR_KME_FIFO_STICKY_ERR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [W-1:0]  fifo_in = '0;
   logic          fifo_in_valid = 1'b0;
   logic          fifo_in_stall_override = 1'b0;
   logic          fifo_clear = 1'b0;
   logic          fifo_out_ack = 1'b0;

   logic          stall0, stall1;
   logic [W-1:0]  out0, out1;
   logic          vld0, vld1;
   logic [CW-1:0] used0, used1, free0, free1;
   logic          ovf0, ovf1, udf0, udf1;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   cr_kme_fifo_param #(.WIDTH(W), .DEPTH(D), .STALL_SLACK(0)) dut0 (
      .clk(clk), .rst(rst), .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
      .fifo_in_stall_override(fifo_in_stall_override), .fifo_clear(fifo_clear),
      .fifo_out_ack(fifo_out_ack), .fifo_in_stall(stall0), .fifo_out(out0),
      .fifo_out_valid(vld0), .fifo_used_slots(used0), .fifo_free_slots(free0),
      .fifo_overflow(ovf0), .fifo_underflow(udf0));

   cr_kme_fifo_param #(.WIDTH(W), .DEPTH(D), .STALL_SLACK(1)) dut1 (
      .clk(clk), .rst(rst), .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
      .fifo_in_stall_override(fifo_in_stall_override), .fifo_clear(fifo_clear),
      .fifo_out_ack(fifo_out_ack), .fifo_in_stall(stall1), .fifo_out(out1),
      .fifo_out_valid(vld1), .fifo_used_slots(used1), .fifo_free_slots(free1),
      .fifo_overflow(ovf1), .fifo_underflow(udf1));

   // ---------------- behavioural model ----------------
   logic [W-1:0] mq[$];
   bit           m_ovf = 1'b0;
   bit           m_udf = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else if (fifo_clear) begin
         mq.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         bit full_now, pop, ovf_e, udf_e;
         full_now = (mq.size() == D);
         pop      = fifo_out_ack && (mq.size() > 0);
         ovf_e    = fifo_in_valid && full_now && !pop;
         udf_e    = fifo_out_ack && (mq.size() == 0);
         if (pop) void'(mq.pop_front());
         if (fifo_in_valid && (!full_now || pop)) mq.push_back(fifo_in);
         m_ovf = STICKY ? (m_ovf | ovf_e) : ovf_e;
         m_udf = STICKY ? (m_udf | udf_e) : udf_e;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         int n;
         logic [W-1:0] head;
         n    = mq.size();
         head = (n != 0) ? mq[0] : '0;
         chk("m_valid0", 64'(vld0), 64'(n != 0));
         chk("m_out0",   64'(out0), 64'(head));
         chk("m_used0",  64'(used0), 64'(n));
         chk("m_free0",  64'(free0), 64'(D - n));
         chk("m_stall0", 64'(stall0), 64'(((D - n) <= 0) && !fifo_in_stall_override));
         chk("m_ovf0",   64'(ovf0), 64'(m_ovf));
         chk("m_udf0",   64'(udf0), 64'(m_udf));
         chk("m_valid1", 64'(vld1), 64'(n != 0));
         chk("m_out1",   64'(out1), 64'(head));
         chk("m_used1",  64'(used1), 64'(n));
         chk("m_stall1", 64'(stall1), 64'(((D - n) <= 1) && !fifo_in_stall_override));
         chk("m_ovf1",   64'(ovf1), 64'(m_ovf));
         chk("m_udf1",   64'(udf1), 64'(m_udf));
      end
   end

   // Apply inputs, let one rising edge pass, return just after the falling edge.
   task automatic step(input bit v, input logic [W-1:0] d, input bit a, input bit c, input bit o);
      fifo_in_valid          = v;
      fifo_in                = d;
      fifo_out_ack           = a;
      fifo_clear             = c;
      fifo_in_stall_override = o;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      #1 rst = 1'b0;
      @(negedge clk); #1;

      // Reset state
      chk("rst_valid", 64'(vld0), 64'd0);
      chk("rst_out",   64'(out0), 64'd0);
      chk("rst_free",  64'(free0), 64'd4);
      chk("rst_stall", 64'(stall0), 64'd0);

      // Fill, then one extra write
      for (int i = 1; i <= 4; i++) step(1, W'(i), 0, 0, 0);
      chk("fill_stall", 64'(stall0), 64'd1);
      chk("fill_free",  64'(free0), 64'd0);
      step(1, 32'h5, 0, 0, 0);
      chk("ovf_set", 64'(ovf0), 64'd1);
      step(0, 0, 0, 0, 0);
      chk("ovf_after", 64'(ovf0), STICKY ? 64'd1 : 64'd0);
      for (int i = 1; i <= 4; i++) begin
         chk("drain_data", 64'(out0), 64'(i));
         step(0, 0, 1, 0, 0);
      end
      chk("drain_empty", 64'(vld0), 64'd0);

      // Ack while empty
      step(0, 0, 1, 0, 0);
      chk("udf_set",  64'(udf0), 64'd1);
      chk("udf_used", 64'(used0), 64'd0);
      chk("udf_out",  64'(out0), 64'd0);
      step(0, 0, 0, 0, 0);
      chk("udf_after", 64'(udf0), STICKY ? 64'd1 : 64'd0);
      step(0, 0, 0, 1, 0);
      chk("udf_clr", 64'(udf0), 64'd0);

      // Simultaneous read/write at count=1, then at full, across the wrap
      step(1, 32'h100, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(1, W'(32'h101 + i), 1, 0, 0);
         chk("rw1_used", 64'(used0), 64'd1);
      end
      for (int i = 0; i < 3; i++) step(1, W'(32'h200 + i), 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(1, W'(32'h300 + i), 1, 0, 0);
         chk("rw4_used", 64'(used0), 64'd4);
         chk("rw4_ovf",  64'(ovf0), 64'd0);
      end
      chk("rw4_head", 64'(out0), 64'h306);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);

      // Stall slack and override with 3 entries
      for (int i = 0; i < 3; i++) step(1, W'(32'h400 + i), 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("slack_stall1", 64'(stall1), 64'd1);
      chk("slack_stall0", 64'(stall0), 64'd0);
      fifo_in_stall_override = 1'b1;
      #1;
      chk("ovr_stall1", 64'(stall1), 64'd0);
      step(0, 0, 1, 0, 1);

      // Clear with write, 2 entries held
      chk("pre_clr_used", 64'(used0), 64'd2);
      step(1, 32'h500, 0, 1, 0);
      chk("clr_used",  64'(used0), 64'd0);
      chk("clr_valid", 64'(vld0), 64'd0);
      chk("clr_free",  64'(free0), 64'd4);
      chk("clr_ovf",   64'(ovf0), 64'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) < 60), $urandom, ($urandom_range(0, 99) < 50),
              ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 20));
      end

      // Async reset mid-burst
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, W'(32'h600 + i), 0, 0, 0);
      fifo_in_valid = 1'b1;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 64'(vld0), 64'd0);
      chk("arst_out",   64'(out0), 64'd0);
      chk("arst_used",  64'(used0), 64'd0);
      chk("arst_free",  64'(free0), 64'd4);
      chk("arst_stall", 64'(stall0), 64'd0);
      chk("arst_ovf",   64'(ovf0), 64'd0);
      chk("arst_udf",   64'(udf0), 64'd0);
      fifo_in_valid = 1'b0;
      @(negedge clk); #1;
      rst = 1'b0;
      step(1, 32'h700, 0, 0, 0);
      chk("post_rst_head", 64'(out0), 64'h700);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
